// File: rtl/bridge_dataslot_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bridge_dataslot_reader_pkg
// Description : Shared types for the dataslot reader: bridge bus word and
//               address types, the reader state enum and slot addressing.
// Revision    : 1.0 - initial release
// ============================================================================
package bridge_dataslot_reader_pkg;

    typedef logic [31:0] bridge_addr_t;
    typedef logic [31:0] bridge_data_t;

    localparam int DATASLOT_BYTES = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD0   = 3'd1,
        WAIT0 = 3'd2,
        RD1   = 3'd3,
        WAIT1 = 3'd4,
        RESP  = 3'd5
    } dataslot_rd_state_t;

    // Byte address of one 32-bit word of a slot; wraps modulo 2^32 by design.
    function automatic bridge_addr_t slot_word_addr(
        input bridge_addr_t base,
        input logic [4:0]   slot,
        input logic         word_sel
    );
        bridge_addr_t offset;
        offset = bridge_addr_t'(slot) * bridge_addr_t'(DATASLOT_BYTES);
        return base + offset + (word_sel ? 32'd4 : 32'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bridge_dataslot_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_if
// Description : Bridge bus between an initiator and a responder window.
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_if
    import bridge_dataslot_reader_pkg::*;
(
    input logic clk
);

    bridge_addr_t addr;
    logic         rd;
    logic         wr;
    bridge_data_t wr_data;
    bridge_data_t rd_data;
    logic         rd_data_valid;

    modport master (
        output addr,
        output rd,
        output wr,
        output wr_data,
        input  rd_data,
        input  rd_data_valid
    );

    modport slave (
        input  clk,
        input  addr,
        input  rd,
        input  wr,
        input  wr_data,
        output rd_data,
        output rd_data_valid
    );

endinterface
`default_nettype wire

// File: rtl/bridge_dataslot_reader.sv
`default_nettype none
// ============================================================================
// Module      : bridge_dataslot_reader
// Description : Read-only bridge initiator fetching one 64-bit dataslot entry
//               as two word reads, with a per-read timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module bridge_dataslot_reader
    import bridge_dataslot_reader_pkg::*;
#(
    parameter bridge_addr_t BASE_ADDR = 32'h0000_0000,
    parameter int           TIMEOUT   = 15
) (
    input  wire logic         clk,
    input  wire logic         reset,
    bus_if.master             bridge,
    input  wire logic         req_valid,
    output logic              req_ready,
    input  wire logic [4:0]   req_slot,
    output logic              resp_valid,
    input  wire logic         resp_ready,
    output bridge_data_t      resp_word0,
    output bridge_data_t      resp_word1,
    output logic              resp_error
);

    // Last counter value before giving up: a wait lasts exactly TIMEOUT cycles.
    localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT - 1);

    dataslot_rd_state_t r_state;
    dataslot_rd_state_t w_state_next;

    logic [4:0]   r_slot;
    bridge_addr_t r_addr;
    logic [7:0]   r_cnt;
    bridge_data_t r_word0;
    bridge_data_t r_word1;
    logic         r_error;

    logic w_rd;
    logic w_req_ready;
    logic w_resp_valid;
    logic w_timeout_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_rd          = 1'b0;
        w_req_ready   = 1'b0;
        w_resp_valid  = 1'b0;
        w_timeout_hit = (r_cnt == C_CNT_LAST);
        case (r_state)
            IDLE: begin
                w_req_ready = 1'b1;
                if (req_valid) begin
                    w_state_next = RD0;
                end
            end
            RD0: begin
                w_rd         = 1'b1;
                w_state_next = WAIT0;
            end
            WAIT0: begin
                if (bridge.rd_data_valid) begin
                    w_state_next = RD1;
                end else if (w_timeout_hit) begin
                    w_state_next = RESP;
                end
            end
            RD1: begin
                w_rd         = 1'b1;
                w_state_next = WAIT1;
            end
            WAIT1: begin
                if (bridge.rd_data_valid || w_timeout_hit) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                w_resp_valid = 1'b1;
                if (resp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Address is loaded one cycle ahead of each RD state and then held.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot  <= 5'd0;
            r_addr  <= BASE_ADDR;
            r_cnt   <= 8'd0;
            r_word0 <= '0;
            r_word1 <= '0;
            r_error <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_slot  <= req_slot;
                        r_addr  <= slot_word_addr(BASE_ADDR, req_slot, 1'b0);
                        r_word0 <= '0;
                        r_word1 <= '0;
                        r_error <= 1'b0;
                    end
                end
                RD0, RD1: begin
                    r_cnt <= 8'd0;
                end
                WAIT0: begin
                    if (bridge.rd_data_valid) begin
                        r_word0 <= bridge.rd_data;
                        r_addr  <= slot_word_addr(BASE_ADDR, r_slot, 1'b1);
                    end else if (w_timeout_hit) begin
                        r_error <= 1'b1;
                        r_word0 <= '0;
                        r_word1 <= '0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                WAIT1: begin
                    if (bridge.rd_data_valid) begin
                        r_word1 <= bridge.rd_data;
                    end else if (w_timeout_hit) begin
                        r_error <= 1'b1;
                        r_word0 <= '0;
                        r_word1 <= '0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bridge.addr    = r_addr;
    assign bridge.rd      = w_rd;
    assign bridge.wr      = 1'b0;
    assign bridge.wr_data = '0;

    assign req_ready  = w_req_ready;
    assign resp_valid = w_resp_valid;
    assign resp_word0 = r_word0;
    assign resp_word1 = r_word1;
    assign resp_error = r_error;

endmodule
`default_nettype wire
